// File: rtl/fifo_rd_stream_if.sv
// rtl/fifo_rd_stream_if.sv - output stream bundle of fifo_rd_stream (m_par present with FIFO_RD_PARITY_EN)
interface fifo_rd_stream_if #(
    parameter int DSIZE = 8
);
    logic             m_valid;
    logic             m_ready;
    logic [DSIZE-1:0] m_data;
    logic             m_last;
`ifdef FIFO_RD_PARITY_EN
    logic             m_par;

    modport master (output m_valid, output m_data, output m_last, output m_par, input m_ready);
    modport slave  (input m_valid, input m_data, input m_last, input m_par, output m_ready);
`else
    modport master (output m_valid, output m_data, output m_last, input m_ready);
    modport slave  (input m_valid, input m_data, input m_last, output m_ready);
`endif
endinterface

// File: rtl/fifo_rd_stream.sv
// rtl/fifo_rd_stream.sv - FIFO read-side to valid/ready stream with 2-entry buffer, packet tagging;
// optional per-word even parity with FIFO_RD_PARITY_EN
module fifo_rd_stream #(
    parameter int DSIZE   = 8,
    parameter int PKT_LEN = 16
) (
    input  logic             rclk,
    input  logic             rrst,
    input  logic             flush,
    input  logic             rempty,
    input  logic             aempty,
    input  logic [DSIZE-1:0] rdata,
    output logic             rinc,
    output logic             stat_low,
    fifo_rd_stream_if.master m
);
    localparam int IW = (PKT_LEN > 1) ? $clog2(PKT_LEN) : 1;
    localparam logic [IW-1:0] LAST_IDX = IW'(PKT_LEN - 1);
`ifdef FIFO_RD_PARITY_EN
    localparam int PW = 1;
`else
    localparam int PW = 0;
`endif
    // Entry layout: {[parity], last_tag, data}
    localparam int EW = DSIZE + 1 + PW;

    localparam logic [1:0] EMPTY = 2'd0;
    localparam logic [1:0] ONE   = 2'd1;
    localparam logic [1:0] FULL  = 2'd2;

    logic [1:0]    state;
    logic [IW-1:0] idx;
    logic [EW-1:0] head;
    logic [EW-1:0] tail;
    logic [EW-1:0] in_entry;
    logic          in_last;
    logic          push;
    logic          pop;

    // Pop strobe sees only registered occupancy, never m_ready, so back-pressure cannot reach the FIFO combinationally
    assign rinc    = !rrst && !flush && !rempty && (state != FULL);
    assign push    = rinc;
    assign pop     = (state != EMPTY) && m.m_ready;
    assign in_last = (idx == LAST_IDX);

`ifdef FIFO_RD_PARITY_EN
    assign in_entry = {^rdata, in_last, rdata};
    assign m.m_par  = head[EW-1];
`else
    assign in_entry = {in_last, rdata};
`endif

    assign m.m_valid = (state != EMPTY);
    assign m.m_data  = head[DSIZE-1:0];
    assign m.m_last  = head[DSIZE];

    always_ff @(posedge rclk) begin
        if (rrst) begin
            state    <= EMPTY;
            idx      <= '0;
            head     <= '0;
            tail     <= '0;
            stat_low <= 1'b0;
        end else begin
            stat_low <= aempty;
            if (flush) begin
                state <= EMPTY;
                idx   <= '0;
            end else begin
                if (push) begin
                    idx <= in_last ? '0 : idx + 1'b1;
                end
                case (state)
                    EMPTY: begin
                        if (push) begin
                            head  <= in_entry;
                            state <= ONE;
                        end
                    end
                    ONE: begin
                        if (push && pop) begin
                            head <= in_entry;
                        end else if (push) begin
                            tail  <= in_entry;
                            state <= FULL;
                        end else if (pop) begin
                            state <= EMPTY;
                        end
                    end
                    FULL: begin
                        if (pop) begin
                            head  <= tail;
                            state <= ONE;
                        end
                    end
                    default: state <= EMPTY;
                endcase
            end
        end
    end
endmodule

// File: tb/tb_fifo_rd_stream.sv
// tb/tb_fifo_rd_stream.sv - directed bench for fifo_rd_stream driven from a queue-modelled FWFT FIFO
module tb_fifo_rd_stream;
    logic       rclk = 1'b0;
    logic       rrst;
    logic       flush;
    logic       rempty;
    logic       aempty;
    logic [7:0] rdata;
    logic       rinc;
    logic       stat_low;

    fifo_rd_stream_if #(.DSIZE(8)) s ();

    fifo_rd_stream #(.DSIZE(8), .PKT_LEN(16)) dut (
        .rclk     (rclk),
        .rrst     (rrst),
        .flush    (flush),
        .rempty   (rempty),
        .aempty   (aempty),
        .rdata    (rdata),
        .rinc     (rinc),
        .stat_low (stat_low),
        .m        (s)
    );

    always #5 rclk = ~rclk;

    logic [7:0] q[$];
    logic       last_rinc;
    int         vectors = 0;
    int         miscompares = 0;
    int         rinc_count;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic fifo_drive();
        rempty = (q.size() == 0);
        rdata  = (q.size() != 0) ? q[0] : 8'h00;
    endtask

    task automatic load(input int first, input int last);
        for (int v = first; v <= last; v++) q.push_back(8'(v));
        fifo_drive();
    endtask

    task automatic tick();
        fifo_drive();
        #1;
        last_rinc = rinc;
        @(posedge rclk);
        if (last_rinc) void'(q.pop_front());
        @(negedge rclk);
        fifo_drive();
    endtask

    task automatic drain(input int first, input int last, input int last_at);
        int e = first;
        int n = 0;
        s.m_ready = 1'b1;
        while (e <= last && n < 64) begin
            if (s.m_valid === 1'b1) begin
                check("drain_data", 32'(s.m_data), 32'(e));
                check("drain_last", 32'(s.m_last), (e == last_at) ? 32'd1 : 32'd0);
                e++;
            end
            tick();
            n++;
        end
        check("drain_done", 32'(e), 32'(last + 1));
    endtask

    initial begin
        rrst = 1'b1; flush = 1'b0; aempty = 1'b1; s.m_ready = 1'b1;
        load(8'h01, 8'h20);
        @(negedge rclk);

        // reset held 3 cycles with a non-empty FIFO
        for (int i = 0; i < 3; i++) begin
            tick();
            check("rst_rinc", 32'(last_rinc), 32'd0);
            check("rst_valid", 32'(s.m_valid), 32'd0);
            check("rst_data", 32'(s.m_data), 32'd0);
            check("rst_last", 32'(s.m_last), 32'd0);
            check("rst_stat_low", 32'(stat_low), 32'd0);
        end
        rrst = 1'b0;

        // streaming 0x01..0x20 at one word per cycle
        rinc_count = 0;
        for (int i = 1; i <= 34; i++) begin
            tick();
            if (last_rinc) rinc_count++;
            check("stream_rinc", 32'(last_rinc), (i <= 32) ? 32'd1 : 32'd0);
            if (i == 1) begin
                check("stat_low_hi", 32'(stat_low), 32'd1);
                aempty = 1'b0;
            end
            if (i == 2) check("stat_low_lo", 32'(stat_low), 32'd0);
            if (i <= 32) begin
                check("stream_valid", 32'(s.m_valid), 32'd1);
                check("stream_data", 32'(s.m_data), 32'(i));
                check("stream_last", 32'(s.m_last), (i == 16 || i == 32) ? 32'd1 : 32'd0);
            end else begin
                check("stream_end_valid", 32'(s.m_valid), 32'd0);
            end
        end
        check("stream_rinc_count", 32'(rinc_count), 32'd32);

        // back-pressure for 5 cycles starting with 0x23 at the head
        load(8'h21, 8'h30);
        tick(); tick(); tick();
        check("bp_head", 32'(s.m_data), 32'h23);
        s.m_ready = 1'b0;
        for (int i = 4; i <= 8; i++) begin
            tick();
            if (i >= 5) check("bp_rinc_full", 32'(last_rinc), 32'd0);
            check("bp_valid", 32'(s.m_valid), 32'd1);
            check("bp_data_hold", 32'(s.m_data), 32'h23);
            check("bp_last_hold", 32'(s.m_last), 32'd0);
        end
        check("bp_fifo_left", 32'(q.size()), 32'd12);
        drain(8'h23, 8'h30, 8'h30);

        // FIFO runs empty after 3 words, refills 4 cycles later
        load(8'h31, 8'h33);
        drain(8'h31, 8'h33, -1);
        check("gap_valid_drop", 32'(s.m_valid), 32'd0);
        for (int i = 0; i < 3; i++) begin
            tick();
            check("gap_valid_idle", 32'(s.m_valid), 32'd0);
        end
        load(8'h34, 8'h40);
        drain(8'h34, 8'h40, 8'h40);

        // flush with two words buffered at word 7
        load(8'h41, 8'h60);
        drain(8'h41, 8'h46, -1);
        s.m_ready = 1'b0;
        tick();
        check("fl_pre_data", 32'(s.m_data), 32'h47);
        flush = 1'b1;
        tick();
        check("fl_rinc", 32'(last_rinc), 32'd0);
        check("fl_valid", 32'(s.m_valid), 32'd0);
        flush = 1'b0;
        check("fl_fifo_left", 32'(q.size()), 32'd24);
        drain(8'h49, 8'h58, 8'h58);
        drain(8'h59, 8'h60, -1);

        // reset mid-packet restarts the packet index
        rrst = 1'b1;
        tick();
        check("mid_rst_valid", 32'(s.m_valid), 32'd0);
        rrst = 1'b0;
        load(8'h61, 8'h70);
        drain(8'h61, 8'h70, 8'h70);

`ifdef FIFO_RD_PARITY_EN
        load(8'h07, 8'h07);
        load(8'h03, 8'h03);
        tick();
        check("par_07_data", 32'(s.m_data), 32'h07);
        check("par_07", 32'(s.m_par), 32'd1);
        tick();
        check("par_03_data", 32'(s.m_data), 32'h03);
        check("par_03", 32'(s.m_par), 32'd0);
        tick();
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
